// File: rtl/vga_scan_timing.sv
// vga_scan_timing: raster timing generator (pixel strobe, scan counters, syncs, animation phase); optional SCAN_LOOKAHEAD_EN delays video_on/hsync/vsync one pixel behind row/col
module vga_scan_timing #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int CLK_DIV     = 2,
  parameter int ANIM_FRAMES = 8,
  parameter int ANIM_PHASES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       pix_en,
  output logic [9:0] col,
  output logic [8:0] row,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [2:0] anim_phase
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam int FW = $clog2(ANIM_FRAMES + 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(ANIM_FRAMES - 1);
  localparam logic [2:0] PH_LAST = 3'(ANIM_PHASES - 1);

  logic [DW-1:0] r_div;
  logic          r_pix_en;
  logic [9:0]    r_h;
  logic [9:0]    r_v;
  logic [FW-1:0] r_frm;
  logic [2:0]    r_phase;
  logic [9:0]    r_col;
  logic [8:0]    r_row;
  logic          r_video_on;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_line_tick;
  logic          r_frame_tick;
`ifdef SCAN_LOOKAHEAD_EN
  logic          r_von_d;
  logic          r_hs_d;
  logic          r_vs_d;
`endif
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_frm_wrap;
  logic          w_von;
  logic          w_hs;
  logic          w_vs;

  assign w_h_wrap   = r_pix_en && (r_h == H_LAST);
  assign w_v_wrap   = w_h_wrap && (r_v == V_LAST);
  assign w_frm_wrap = w_v_wrap && (r_frm == FRM_LAST);
  assign w_von      = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs       = !((r_h >= HS_BEG) && (r_h < HS_END));
  assign w_vs       = !((r_v >= VS_BEG) && (r_v < VS_END));

  // Clock divider; pix_en is registered from the last divider count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div    <= '0;
      r_pix_en <= 1'b0;
    end else begin
      r_div    <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      r_pix_en <= (r_div == DIV_LAST);
    end
  end

  // Horizontal and vertical scan counters advance once per pixel
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_pix_en) begin
      r_h <= w_h_wrap ? '0 : r_h + 1'b1;
      if (w_h_wrap) r_v <= w_v_wrap ? '0 : r_v + 1'b1;
    end
  end

  // Frame counter selects the animation phase every ANIM_FRAMES frames
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frm   <= '0;
      r_phase <= '0;
    end else if (w_v_wrap) begin
      r_frm <= w_frm_wrap ? '0 : r_frm + 1'b1;
      if (w_frm_wrap) r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
    end
  end

  // Line/frame pulses follow the wrapping pixel strobe for one clk
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_line_tick  <= w_h_wrap;
      r_frame_tick <= w_v_wrap;
    end
  end

  // Scan outputs load once per pixel from the counter state before it advances
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col      <= 10'h3FF;
      r_row      <= 9'h1FF;
      r_video_on <= 1'b0;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
`ifdef SCAN_LOOKAHEAD_EN
      r_von_d    <= 1'b0;
      r_hs_d     <= 1'b1;
      r_vs_d     <= 1'b1;
`endif
    end else if (r_pix_en) begin
      r_col      <= (r_h < H_ACT) ? r_h : 10'h3FF;
      r_row      <= (r_v < V_ACT) ? r_v[8:0] : 9'h1FF;
`ifdef SCAN_LOOKAHEAD_EN
      r_von_d    <= w_von;
      r_hs_d     <= w_hs;
      r_vs_d     <= w_vs;
      r_video_on <= r_von_d;
      r_hsync    <= r_hs_d;
      r_vsync    <= r_vs_d;
`else
      r_video_on <= w_von;
      r_hsync    <= w_hs;
      r_vsync    <= w_vs;
`endif
    end
  end

  assign pix_en     = r_pix_en;
  assign col        = r_col;
  assign row        = r_row;
  assign video_on   = r_video_on;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign line_tick  = r_line_tick;
  assign frame_tick = r_frame_tick;
  assign anim_phase = r_phase;
endmodule

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing: scan timing bench on a reduced raster (25x19 pixels, 950 clk per frame)
module tb_vga_scan_timing;
  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int D = 2, AF = 8, AP = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
`ifdef SCAN_LOOKAHEAD_EN
  localparam bit LA = 1'b1;
`else
  localparam bit LA = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       pix_en;
  logic [9:0] col;
  logic [8:0] row;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       line_tick;
  logic       frame_tick;
  logic [2:0] anim_phase;

  int nchecks = 0;
  int nerrors = 0;
  int e_cnt = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  vga_scan_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(D), .ANIM_FRAMES(AF), .ANIM_PHASES(AP)
  ) dut (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .col(col), .row(row),
    .video_on(video_on), .hsync(hsync), .vsync(vsync),
    .line_tick(line_tick), .frame_tick(frame_tick), .anim_phase(anim_phase)
  );

  always #5 clk = ~clk;

  // Rising edges since reset was released
  always @(posedge clk or negedge resetn) e_cnt <= !resetn ? 0 : e_cnt + 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outputs after e rising edges: pixel n is presented after edge (n+1)*D+1
  function automatic logic [27:0] model(input int e);
    int p, q, h, v, hq, vq;
    logic pe, von, hs_n, vs_n, lt, ft;
    logic [9:0] c;
    logic [8:0] r;
    logic [2:0] ph;
    p = (e < 1) ? -1 : (e - 1) / D - 1;
    q = LA ? p - 1 : p;
    h = (p < 0) ? 0 : p % HT;
    v = (p < 0) ? 0 : (p / HT) % VT;
    hq = (q < 0) ? 0 : q % HT;
    vq = (q < 0) ? 0 : (q / HT) % VT;
    pe = (e >= D) && (e % D == 0);
    c = (p >= 0 && h < HA) ? 10'(h) : 10'd1023;
    r = (p >= 0 && v < VA) ? 9'(v) : 9'd511;
    von = (q >= 0) && (hq < HA) && (vq < VA);
    hs_n = !((q >= 0) && (hq >= HA + HFP) && (hq < HA + HFP + HS));
    vs_n = !((q >= 0) && (vq >= VA + VFP) && (vq < VA + VFP + VS));
    lt = (p >= 0) && (e == (p + 1) * D + 1) && (h == HT - 1);
    ft = lt && (v == VT - 1);
    ph = (p < 0) ? 3'd0 : 3'((((p + 1) / (HT * VT)) / AF) % AP);
    return {pe, c, r, von, hs_n, vs_n, lt, ft, ph};
  endfunction

  always @(negedge clk) begin
    logic [27:0] act, exp;
    if (chk_en) begin
      act = {pix_en, col, row, video_on, hsync, vsync, line_tick, frame_tick, anim_phase};
      exp = model(e_cnt);
      nchecks++;
      if (act !== exp) begin
        nerrors++;
        $display("FAIL scan e=%0d: got %h expected %h", e_cnt, act, exp);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_col"}, col, 1023);
    check({tag, "_row"}, row, 511);
    check({tag, "_video_on"}, video_on, 0);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_pix_en"}, pix_en, 0);
    check({tag, "_ticks"}, {line_tick, frame_tick}, 0);
    check({tag, "_anim"}, anim_phase, 0);
  endtask

  task automatic release_and_start(input string tag);
    int n;
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!pix_en && n < 10);
    check({tag, "_first_pix_en_clk"}, n, 2);
    @(negedge clk);
    check({tag, "_col0"}, col, 0);
    check({tag, "_row0"}, row, 0);
    check({tag, "_von0"}, video_on, LA ? 0 : 1);
    repeat (D) @(negedge clk);
    check({tag, "_col1"}, col, 1);
    check({tag, "_von1"}, video_on, 1);
    repeat (D) @(negedge clk);
    check({tag, "_col2"}, col, 2);
  endtask

  task automatic wait_lt();
    int n = 0;
    do begin @(negedge clk); n++; end while (!line_tick && n < 200);
    if (!line_tick) check("line_tick_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, k, vlow, c0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    chk_en = 1'b1;
    release_and_start("start");
    n = 0;
    while (col != 10'(HA - 1) && n < 200) begin @(negedge clk); n++; end
    check("last_active_col", col, HA - 1);
    repeat (D) @(negedge clk);
    check("col_after_active", col, 1023);
    check("von_after_active", video_on, LA ? 1 : 0);
    wait_lt();
    c0 = cyc;
    wait_lt();
    check("line_period_clk", cyc - c0, 50);
    wait_lt();
    c0 = cyc;
    n = 0;
    while (hsync && n < 200) begin @(negedge clk); n++; end
    check("hsync_fall_clk", cyc - c0, LA ? 40 : 38);
    c0 = cyc;
    n = 0;
    while (!hsync && n < 200) begin @(negedge clk); n++; end
    check("hsync_low_clk", cyc - c0, 8);
    k = 0;
    while (k < 40) begin
      n = 0;
      vlow = 0;
      do begin @(negedge clk); n++; if (!vsync) vlow++; end while (!frame_tick && n < 2000);
      if (!frame_tick) begin
        check("frame_tick_timeout", 0, 1);
        break;
      end
      k++;
      if (k == 2) begin
        check("frame_period_clk", n, 950);
        check("vsync_low_clk", vlow, 100);
        check("frame_with_line_tick", line_tick, 1);
      end
      if (k == 7) check("anim_f7", anim_phase, 0);
      if (k == 8) check("anim_f8", anim_phase, 1);
      if (k == 16) check("anim_f16", anim_phase, 2);
      if (k == 24) check("anim_f24", anim_phase, 3);
      if (k == 32) check("anim_f32", anim_phase, 0);
      if (k == 40) check("anim_f40", anim_phase, 1);
    end
    n = 0;
    while (!(col == 10'd10 && row == 9'd5) && n < 2000) begin @(negedge clk); n++; end
    check("midframe_pos", {22'd0, row, col}, {22'd0, 9'd5, 10'd10});
    #2;
    resetn = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (2) @(negedge clk);
    release_and_start("restart");
    repeat (100) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
